// File: rtl/matmul_host_ctrl.sv
// Host-side sequencer for a matrix-multiply core: streams A/B rows into memory,
// runs the compute, then returns C rows through a credit-limited 4-entry FIFO.
module matmul_host_ctrl #(
   parameter int DWIDTH       = 16,
   parameter int AWIDTH       = 7,
   parameter int MAT_MUL_SIZE = 8,
   parameter int ROWS         = 8,
   parameter int WR_LAT       = 2,
   parameter int RD_LAT       = 3
) (
   input  logic                           clk,
   input  logic                           resetn,
   input  logic                           go,
   output logic                           busy,
   output logic                           done,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [MAT_MUL_SIZE*DWIDTH-1:0] in_data,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [MAT_MUL_SIZE*DWIDTH-1:0] out_data,
   output logic                           enable_writing_to_mem,
   output logic                           enable_reading_from_mem,
   output logic [AWIDTH-1:0]              addr_pi,
   output logic [MAT_MUL_SIZE*DWIDTH-1:0] data_pi,
   output logic                           we_a,
   output logic                           we_b,
   output logic                           we_c,
   output logic                           start_mat_mul,
   input  logic                           done_mat_mul,
   input  logic [MAT_MUL_SIZE*DWIDTH-1:0] data_from_out_mat
);

   localparam int RW    = MAT_MUL_SIZE * DWIDTH;
   localparam int CMAX  = (ROWS > WR_LAT) ? ROWS : WR_LAT;
   localparam int CW    = $clog2(CMAX + 1);
   localparam int FDEPTH = 4;

   typedef enum logic [2:0] {
      IDLE, LOAD_A, LOAD_B, WR_DRAIN, COMPUTE, SETTLE, READ, FIN
   } state_t;

   state_t          state;
   logic [CW-1:0]   cnt;

   logic            xfer;
   logic            last_row;
   logic            rd_issue;
   logic            push;
   logic            pop;

   logic [WR_LAT-1:0] wr_v;
   logic [WR_LAT-1:0] wr_b;
   logic [RW-1:0]     wr_d [WR_LAT];
   logic [RD_LAT-1:0] rd_v;

   logic [2:0]        inflight;
   logic [2:0]        fifo_cnt;
   logic [1:0]        wptr;
   logic [1:0]        rptr;
   logic [RW-1:0]     fifo [FDEPTH];

   assign in_ready  = (state == LOAD_A) || (state == LOAD_B);
   assign xfer      = in_valid && in_ready;
   assign last_row  = (cnt == CW'(ROWS - 1));

   // A read is only launched when its FIFO slot is already guaranteed, so captures never stall.
   assign rd_issue  = (state == READ) && (cnt < CW'(ROWS)) &&
                      (({1'b0, fifo_cnt} + {1'b0, inflight}) < 4'(FDEPTH));

   assign push      = rd_v[RD_LAT-1];
   assign out_valid = (fifo_cnt != '0);
   assign pop       = out_valid && out_ready;
   assign out_data  = fifo[rptr];

   assign busy                    = (state != IDLE);
   assign done                    = (state == FIN);
   assign enable_writing_to_mem   = (state == LOAD_A) || (state == LOAD_B) || (state == WR_DRAIN);
   assign enable_reading_from_mem = (state == SETTLE) || (state == READ);
   assign start_mat_mul           = (state == COMPUTE);
   assign we_c                    = (state == COMPUTE);
   assign addr_pi                 = (xfer || rd_issue) ? AWIDTH'(cnt) : '0;
   assign we_a                    = wr_v[WR_LAT-1] && !wr_b[WR_LAT-1];
   assign we_b                    = wr_v[WR_LAT-1] &&  wr_b[WR_LAT-1];
   assign data_pi                 = wr_d[WR_LAT-1];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (go) begin
                  state <= LOAD_A;
                  cnt   <= '0;
               end
            end
            LOAD_A: begin
               if (xfer) begin
                  if (last_row) begin
                     state <= LOAD_B;
                     cnt   <= '0;
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
            end
            LOAD_B: begin
               if (xfer) begin
                  if (last_row) begin
                     state <= WR_DRAIN;
                     cnt   <= '0;
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
            end
            WR_DRAIN: begin
               if (cnt == CW'(WR_LAT - 1)) begin
                  state <= COMPUTE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            COMPUTE: begin
               if (done_mat_mul) state <= SETTLE;
            end
            SETTLE: begin
               state <= READ;
               cnt   <= '0;
            end
            READ: begin
               if (rd_issue) cnt <= cnt + CW'(1);
               if ((cnt == CW'(ROWS)) && (inflight == '0) && (fifo_cnt == '0)) begin
                  state <= FIN;
                  cnt   <= '0;
               end
            end
            FIN: begin
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_v     <= '0;
         wr_b     <= '0;
         rd_v     <= '0;
         inflight <= '0;
         fifo_cnt <= '0;
         wptr     <= '0;
         rptr     <= '0;
         for (int unsigned i = 0; i < WR_LAT; i++) wr_d[i] <= '0;
         for (int unsigned i = 0; i < FDEPTH; i++) fifo[i] <= '0;
      end else begin
         wr_v[0] <= xfer;
         wr_b[0] <= (state == LOAD_B);
         wr_d[0] <= xfer ? in_data : '0;
         for (int unsigned i = 1; i < WR_LAT; i++) begin
            wr_v[i] <= wr_v[i-1];
            wr_b[i] <= wr_b[i-1];
            wr_d[i] <= wr_d[i-1];
         end

         rd_v[0] <= rd_issue;
         for (int unsigned i = 1; i < RD_LAT; i++) rd_v[i] <= rd_v[i-1];
         inflight <= inflight + 3'(rd_issue) - 3'(push);

         if (push) begin
            fifo[wptr] <= data_from_out_mat;
            wptr       <= wptr + 2'd1;
         end
         if (pop) rptr <= rptr + 2'd1;
         fifo_cnt <= fifo_cnt + 3'(push) - 3'(pop);
      end
   end

endmodule

// File: tb/tb_matmul_host_ctrl.sv
// Bench for matmul_host_ctrl: surrounding memory/compute model, randomized rows,
// C rows expected from a plain matrix product of the rows the host sent.
module tb_matmul_host_ctrl;

   localparam int DWIDTH       = 16;
   localparam int AWIDTH       = 7;
   localparam int MAT_MUL_SIZE = 8;
   localparam int ROWS         = 8;
   localparam int WR_LAT       = 2;
   localparam int RD_LAT       = 3;
   localparam int RW           = MAT_MUL_SIZE * DWIDTH;
   localparam int MEMD         = 2 ** AWIDTH;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   logic go = 1'b0;
   logic in_valid = 1'b0;
   logic out_ready = 1'b0;
   logic done_mat_mul = 1'b0;
   logic [RW-1:0] in_data = '0;
   logic [RW-1:0] data_from_out_mat;

   logic busy, done, in_ready, out_valid;
   logic enable_writing_to_mem, enable_reading_from_mem;
   logic we_a, we_b, we_c, start_mat_mul;
   logic [RW-1:0] out_data, data_pi;
   logic [AWIDTH-1:0] addr_pi;

   int checks = 0;
   int failures = 0;
   int t = 0;

   logic [RW-1:0] mem_a [MEMD];
   logic [RW-1:0] mem_b [MEMD];
   logic [RW-1:0] mem_c [MEMD];
   logic [AWIDTH-1:0] ah [4];

   logic [RW-1:0] rows_a [MEMD];
   logic [RW-1:0] rows_b [MEMD];
   logic [RW-1:0] exp_c  [MEMD];
   int            we_kind [int];
   logic [RW-1:0] we_data [int];

   always #5 clk = ~clk;

   matmul_host_ctrl #(
      .DWIDTH(DWIDTH), .AWIDTH(AWIDTH), .MAT_MUL_SIZE(MAT_MUL_SIZE),
      .ROWS(ROWS), .WR_LAT(WR_LAT), .RD_LAT(RD_LAT)
   ) dut (
      .clk(clk), .resetn(resetn), .go(go), .busy(busy), .done(done),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .enable_writing_to_mem(enable_writing_to_mem),
      .enable_reading_from_mem(enable_reading_from_mem),
      .addr_pi(addr_pi), .data_pi(data_pi),
      .we_a(we_a), .we_b(we_b), .we_c(we_c),
      .start_mat_mul(start_mat_mul), .done_mat_mul(done_mat_mul),
      .data_from_out_mat(data_from_out_mat)
   );

   // Memory model: address arrives first, write data/enable WR_LAT later, read data RD_LAT later.
   always @(negedge clk) begin
      if (we_a) mem_a[ah[WR_LAT-1]] <= data_pi;
      if (we_b) mem_b[ah[WR_LAT-1]] <= data_pi;
      data_from_out_mat <= mem_c[ah[RD_LAT-1]];
      ah[0] <= addr_pi;
      for (int j = 1; j < 4; j++) ah[j] <= ah[j-1];
   end

   function automatic logic [RW-1:0] rand_row();
      logic [RW-1:0] r;
      for (int e = 0; e < MAT_MUL_SIZE; e++) r[e*DWIDTH +: DWIDTH] = DWIDTH'($urandom);
      return r;
   endfunction

   function automatic logic [RW-1:0] mm_row(input logic [RW-1:0] a_row, input logic [RW-1:0] b [MEMD]);
      logic [RW-1:0] r;
      logic [DWIDTH-1:0] acc;
      r = '0;
      for (int j = 0; j < MAT_MUL_SIZE; j++) begin
         acc = '0;
         for (int k = 0; k < ROWS; k++)
            acc = acc + DWIDTH'(a_row[k*DWIDTH +: DWIDTH] * b[k][j*DWIDTH +: DWIDTH]);
         r[j*DWIDTH +: DWIDTH] = acc;
      end
      return r;
   endfunction

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: got %b expected %b at step %0d", tag, obs, exp, t);
      end
   endtask

   task automatic chkw(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: got %0h expected %0h at step %0d", tag, obs, exp, t);
      end
   endtask

   task automatic chki(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: got %0d expected %0d at step %0d", tag, obs, exp, t);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      t++;
   endtask

   task automatic wcheck();
      int k;
      logic [RW-1:0] d;
      k = we_kind.exists(t) ? we_kind[t] : 0;
      d = (k != 0) ? we_data[t] : '0;
      chk1("we_a", we_a, k == 1);
      chk1("we_b", we_b, k == 2);
      chkw("data_pi", data_pi, d);
   endtask

   task automatic flags_zero(input string tag);
      chkw(tag, RW'({busy, done, in_ready, out_valid, enable_writing_to_mem,
                     enable_reading_from_mem, we_a, we_b, we_c, start_mat_mul}), '0);
      chkw({tag, "_addr"}, RW'(addr_pi), '0);
      chkw({tag, "_data_pi"}, data_pi, '0);
      chkw({tag, "_out_data"}, out_data, '0);
   endtask

   // iv_mode: 0 always valid, 1 alternating, 2 random; or_mode: 0 always ready, 1 stalled 20 cycles, 2 random
   task automatic run_job(input int iv_mode, input int or_mode, input int hold, input bit go_mid);
      int idx, oi, ncyc, hi, nz, maxa, lastx, pop_t, dones;
      for (int r = 0; r < ROWS; r++) begin
         rows_a[r] = rand_row();
         rows_b[r] = rand_row();
      end
      for (int r = 0; r < ROWS; r++) exp_c[r] = mm_row(rows_a[r], rows_b);
      we_kind.delete();
      we_data.delete();

      go = 1'b1;
      #1;
      chk1("busy_before_go", busy, 1'b0);
      tick();
      go = 1'b0;

      idx = 0;
      lastx = 0;
      for (int n = 0; n < 200 && idx < 2*ROWS; n++) begin
         if (iv_mode == 0)      in_valid = 1'b1;
         else if (iv_mode == 1) in_valid = (n % 2 == 0);
         else                   in_valid = 1'($urandom_range(0, 1));
         in_data = (idx < ROWS) ? rows_a[idx] : rows_b[idx-ROWS];
         #1;
         chk1("busy_load", busy, 1'b1);
         chk1("in_ready_load", in_ready, 1'b1);
         chk1("wr_en_load", enable_writing_to_mem, 1'b1);
         chkw("addr_load", RW'(addr_pi), in_valid ? RW'(idx % ROWS) : '0);
         wcheck();
         if (in_valid) begin
            we_kind[t + WR_LAT] = (idx < ROWS) ? 1 : 2;
            we_data[t + WR_LAT] = in_data;
            idx++;
            lastx = t;
         end
         tick();
      end
      in_valid = 1'b0;
      chki("rows_accepted", idx, 2*ROWS);

      ncyc = 0;
      while (!start_mat_mul && ncyc < 20) begin
         #1;
         chk1("in_ready_drain", in_ready, 1'b0);
         chk1("wr_en_drain", enable_writing_to_mem, 1'b1);
         wcheck();
         tick();
         ncyc++;
      end
      chki("compute_start_step", t, lastx + WR_LAT + 1);

      hi = 0;
      while (start_mat_mul && hi < hold + 5) begin
         done_mat_mul = (hi == hold - 1);
         go = go_mid && (hi == hold / 2);
         #1;
         chk1("we_c_compute", we_c, 1'b1);
         chk1("wr_en_compute", enable_writing_to_mem, 1'b0);
         chk1("busy_compute", busy, 1'b1);
         wcheck();
         if (done_mat_mul)
            for (int r = 0; r < ROWS; r++) mem_c[r] = mm_row(mem_a[r], mem_b);
         tick();
         hi++;
      end
      done_mat_mul = 1'b0;
      go = 1'b0;
      chki("start_hold_cycles", hi, hold);

      #1;
      chk1("settle_rd_en", enable_reading_from_mem, 1'b1);
      chk1("settle_we_c", we_c, 1'b0);
      chk1("settle_out_valid", out_valid, 1'b0);
      tick();

      oi = 0; nz = 0; maxa = 0; pop_t = 0; dones = 0;
      for (int n = 0; n < 300 && oi < ROWS; n++) begin
         if (or_mode == 0)      out_ready = 1'b1;
         else if (or_mode == 1) out_ready = (n >= 20);
         else                   out_ready = 1'($urandom_range(0, 1));
         #1;
         chk1("rd_en_read", enable_reading_from_mem, 1'b1);
         chk1("done_early", done, 1'b0);
         wcheck();
         if (or_mode == 1 && n < 20) begin
            if (addr_pi != '0) nz++;
            if (int'(addr_pi) > maxa) maxa = int'(addr_pi);
            if (n >= 5) begin
               chk1("stall_out_valid", out_valid, 1'b1);
               chkw("stall_head", out_data, exp_c[0]);
            end
         end
         if (out_valid && out_ready) begin
            chkw("out_row", out_data, exp_c[oi]);
            oi++;
            pop_t = t;
         end
         tick();
      end
      out_ready = 1'b0;
      chki("rows_out", oi, ROWS);
      if (or_mode == 1) begin
         chki("stall_reads_issued", nz, 3);
         chki("stall_max_addr", maxa, 3);
      end

      for (int n = 0; n < 6; n++) begin
         #1;
         chk1("busy_tail", busy, dones == 0);
         if (done) begin
            dones++;
            chki("done_step", t, pop_t + 2);
         end
         tick();
      end
      chki("done_pulses", dones, 1);
   endtask

   task automatic reset_mid_load();
      go = 1'b1;
      tick();
      go = 1'b0;
      in_valid = 1'b1;
      for (int n = 0; n < ROWS + 3; n++) begin
         in_data = rand_row();
         tick();
      end
      #1;
      chk1("pre_reset_in_ready", in_ready, 1'b1);
      chk1("pre_reset_we_b", we_b, 1'b1);
      #1;
      resetn = 1'b0;
      #1;
      flags_zero("async_reset");
      for (int n = 0; n < 3; n++) begin
         tick();
         #1;
         flags_zero("reset_hold");
      end
      in_valid = 1'b0;
      resetn = 1'b1;
      tick();
      #1;
      flags_zero("after_reset");
      tick();
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      flags_zero("reset_state");
      resetn = 1'b1;
      tick();

      run_job(0, 0, 5, 1'b0);
      run_job(1, 0, 3, 1'b0);
      run_job(0, 0, 50, 1'b0);
      run_job(2, 1, 4, 1'b0);
      reset_mid_load();
      run_job(0, 2, 6, 1'b1);
      run_job(2, 2, 1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
